// File: rtl/rgb_pwm_fader_if.sv
// rtl/rgb_pwm_fader_if.sv - target-colour handshake between a colour source and rgb_pwm_fader
interface rgb_pwm_fader_if #(
  parameter int PWM_BITS = 8
);
  logic                    COLOR_VALID;
  logic [3*PWM_BITS-1:0]   COLOR_RGB;
  logic                    COLOR_READY;

  modport master (output COLOR_VALID, output COLOR_RGB, input COLOR_READY);
  modport slave  (input COLOR_VALID, input COLOR_RGB, output COLOR_READY);
endinterface

// File: rtl/rgb_pwm_fader.sv
// rtl/rgb_pwm_fader.sv - tri-colour active-low LED PWM with frame-synchronous one-level-per-step fades
module rgb_pwm_fader #(
  parameter int PWM_BITS    = 8,
  parameter int PRESCALE    = 188,
  parameter int FADE_FRAMES = 4
) (
  input  logic            CLK_48,
  input  logic            RST_N,
  rgb_pwm_fader_if.slave  color_if,
  output logic            FADE_BUSY,
  output logic            FRAME_STROBE,
  output logic            LED_R,
  output logic            LED_G,
  output logic            LED_B
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FC_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FADE_FRAMES - 1);

  typedef enum logic {S_IDLE, S_FADING} state_e;

  state_e                      state_q, state_d;
  logic [PS_W-1:0]             presc_q, presc_d;
  logic [PWM_BITS-1:0]         pwm_ctr_q, pwm_ctr_d;
  logic [FC_W-1:0]             fade_cnt_q, fade_cnt_d;
  logic [2:0][PWM_BITS-1:0]    cur_q, cur_d;
  logic [2:0][PWM_BITS-1:0]    tgt_q, tgt_d;
  logic [2:0][PWM_BITS-1:0]    shd_q, shd_d;
  logic [2:0]                  led_q, led_d;
  logic                        strobe_q, strobe_d;

  logic tick, frame_evt, accept, all_eq, step, ready;

  assign tick      = (presc_q == PS_LAST);
  assign frame_evt = tick && (&pwm_ctr_q);
  assign accept    = (state_q == S_IDLE) && color_if.COLOR_VALID;
  assign all_eq    = (cur_q == tgt_q);
  assign step      = (state_q == S_FADING) && frame_evt && (fade_cnt_q == FC_LAST);

  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      presc_q    <= '0;
      pwm_ctr_q  <= '0;
      fade_cnt_q <= '0;
      cur_q      <= '0;
      tgt_q      <= '0;
      shd_q      <= '0;
      led_q      <= '1;
      strobe_q   <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      pwm_ctr_q  <= pwm_ctr_d;
      fade_cnt_q <= fade_cnt_d;
      cur_q      <= cur_d;
      tgt_q      <= tgt_d;
      shd_q      <= shd_d;
      led_q      <= led_d;
      strobe_q   <= strobe_d;
    end
  end

  // Shadow levels latch the pre-step cur_q, so a step shows from the following frame.
  always_comb begin
    presc_d    = tick ? '0 : presc_q + 1'b1;
    pwm_ctr_d  = tick ? pwm_ctr_q + 1'b1 : pwm_ctr_q;
    shd_d      = frame_evt ? cur_q : shd_q;
    tgt_d      = accept ? color_if.COLOR_RGB : tgt_q;
    strobe_d   = frame_evt;
    fade_cnt_d = fade_cnt_q;
    if (accept) begin
      fade_cnt_d = '0;
    end else if ((state_q == S_FADING) && frame_evt) begin
      fade_cnt_d = step ? '0 : fade_cnt_q + 1'b1;
    end
    cur_d = cur_q;
    led_d = '1;
    for (int i = 0; i < 3; i++) begin
      if (step && (cur_q[i] < tgt_q[i])) begin
        cur_d[i] = cur_q[i] + 1'b1;
      end else if (step && (cur_q[i] > tgt_q[i])) begin
        cur_d[i] = cur_q[i] - 1'b1;
      end
      led_d[i] = ~(pwm_ctr_q < shd_q[i]);
    end
  end

  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_FADING;
      S_FADING: if (all_eq) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == S_IDLE);
  end

  assign color_if.COLOR_READY = ready;
  assign FADE_BUSY            = ~ready;
  assign FRAME_STROBE         = strobe_q;
  assign LED_R                = led_q[2];
  assign LED_G                = led_q[1];
  assign LED_B                = led_q[0];

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// tb/tb_rgb_pwm_fader.sv - directed self-checking bench for rgb_pwm_fader
module tb_rgb_pwm_fader;

  logic clk = 1'b0;
  logic rst_n, rst_n_f;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rgb_pwm_fader_if #(.PWM_BITS(8)) if_def ();
  rgb_pwm_fader_if #(.PWM_BITS(8)) if_fast ();
  rgb_pwm_fader_if #(.PWM_BITS(4)) if_mid ();

  logic d_busy, d_strobe, d_led_r, d_led_g, d_led_b;
  logic f_busy, f_strobe, f_led_r, f_led_g, f_led_b;
  logic m_busy, m_strobe, m_led_r, m_led_g, m_led_b;

  rgb_pwm_fader u_def (
    .CLK_48(clk), .RST_N(rst_n), .color_if(if_def),
    .FADE_BUSY(d_busy), .FRAME_STROBE(d_strobe),
    .LED_R(d_led_r), .LED_G(d_led_g), .LED_B(d_led_b)
  );

  rgb_pwm_fader #(.PWM_BITS(8), .PRESCALE(1), .FADE_FRAMES(1)) u_fast (
    .CLK_48(clk), .RST_N(rst_n_f), .color_if(if_fast),
    .FADE_BUSY(f_busy), .FRAME_STROBE(f_strobe),
    .LED_R(f_led_r), .LED_G(f_led_g), .LED_B(f_led_b)
  );

  rgb_pwm_fader #(.PWM_BITS(4), .PRESCALE(188), .FADE_FRAMES(2)) u_mid (
    .CLK_48(clk), .RST_N(rst_n), .color_if(if_mid),
    .FADE_BUSY(m_busy), .FRAME_STROBE(m_strobe),
    .LED_R(m_led_r), .LED_G(m_led_g), .LED_B(m_led_b)
  );

  // Per-frame lit-cycle counts; a window runs from one strobe sample to the next.
  int f_acc_r, f_acc_g, f_acc_b, f_last_r, f_last_g, f_last_b;
  always @(negedge clk) begin
    if (!rst_n_f) begin
      f_acc_r <= 0; f_acc_g <= 0; f_acc_b <= 0;
      f_last_r <= 0; f_last_g <= 0; f_last_b <= 0;
    end else if (f_strobe) begin
      f_last_r <= f_acc_r; f_last_g <= f_acc_g; f_last_b <= f_acc_b;
      f_acc_r <= int'(!f_led_r); f_acc_g <= int'(!f_led_g); f_acc_b <= int'(!f_led_b);
    end else begin
      f_acc_r <= f_acc_r + int'(!f_led_r);
      f_acc_g <= f_acc_g + int'(!f_led_g);
      f_acc_b <= f_acc_b + int'(!f_led_b);
    end
  end

  int m_acc_r, m_acc_b, m_win;
  int m_hist_r [16];
  int m_hist_b [16];
  always @(negedge clk) begin
    if (!rst_n) begin
      m_acc_r <= 0; m_acc_b <= 0; m_win <= 0;
    end else if (m_strobe) begin
      if (m_win < 16) begin
        m_hist_r[m_win] <= m_acc_r;
        m_hist_b[m_win] <= m_acc_b;
      end
      m_win   <= m_win + 1;
      m_acc_r <= int'(!m_led_r);
      m_acc_b <= int'(!m_led_b);
    end else begin
      m_acc_r <= m_acc_r + int'(!m_led_r);
      m_acc_b <= m_acc_b + int'(!m_led_b);
    end
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_strobe_f(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      tick();
      if (f_strobe) seen = 1'b1;
    end
    if (!seen) chk(tag, 0, 1);
  endtask

  task automatic proc_def();
    int n = 0;
    int lows = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 50000 && !seen; i++) begin
      tick();
      n++;
      if (n == 1000) begin
        if_def.COLOR_VALID = 1'b1;
        if_def.COLOR_RGB   = {8'd1, 8'd1, 8'd1};
      end
      if (n == 1001) begin
        chk("def_accept_busy", d_busy, 1);
        if_def.COLOR_VALID = 1'b0;
      end
      lows += int'(!d_led_r) + int'(!d_led_g) + int'(!d_led_b);
      if (d_strobe) seen = 1'b1;
    end
    chk("def_first_strobe", n, 48128);
    chk("def_level0_lows", lows, 0);
    tick();
    chk("def_strobe_width", d_strobe, 0);
  endtask

  task automatic proc_fast();
    int  nstb = 0;
    int  since = 0;
    bit  done = 1'b0;
    bit  rej = 1'b0;
    repeat (5) tick();
    if_fast.COLOR_VALID = 1'b1;
    if_fast.COLOR_RGB   = 24'h000000;
    tick();
    chk("eq_ready_low", if_fast.COLOR_READY, 0);
    chk("eq_busy", f_busy, 1);
    if_fast.COLOR_VALID = 1'b0;
    tick();
    chk("eq_ready_back", if_fast.COLOR_READY, 1);
    wait_strobe_f("eq_strobe_a");
    wait_strobe_f("eq_strobe_b");
    chk("eq_leds_off", f_last_r + f_last_g + f_last_b, 0);

    repeat (10) tick();
    if_fast.COLOR_VALID = 1'b1;
    if_fast.COLOR_RGB   = {8'd255, 8'd0, 8'd128};
    tick();
    chk("fade_ready_low", if_fast.COLOR_READY, 0);
    if_fast.COLOR_VALID = 1'b0;
    for (int i = 0; i < 70000 && !done; i++) begin
      tick();
      if (rej) begin
        chk("busy_reject_ready", if_fast.COLOR_READY, 0);
        if_fast.COLOR_VALID = 1'b0;
        rej = 1'b0;
      end
      if (if_fast.COLOR_READY) begin
        done = 1'b1;
      end else if (f_strobe) begin
        nstb++;
        since = 0;
        case (nstb)
          5: begin
            if_fast.COLOR_VALID = 1'b1;
            if_fast.COLOR_RGB   = 24'h0a0a0a;
            rej = 1'b1;
          end
          129: begin chk("b_frame128", f_last_b, 127); chk("r_frame128", f_last_r, 127); end
          130: begin chk("b_frame129", f_last_b, 128); chk("r_frame129", f_last_r, 128); end
          200: begin
            chk("b_saturated", f_last_b, 128);
            chk("r_frame199", f_last_r, 198);
            chk("g_frame199", f_last_g, 0);
          end
          250: begin
            if_fast.COLOR_VALID = 1'b1;
            if_fast.COLOR_RGB   = 24'h0a0a0a;
          end
          default: ;
        endcase
      end else begin
        since++;
      end
    end
    chk("fade_done", done, 1);
    chk("fade_frames", nstb, 255);
    chk("ready_rise_lag", since, 0);
    tick();
    chk("held_accept", if_fast.COLOR_READY, 0);
    if_fast.COLOR_VALID = 1'b0;

    wait_strobe_f("steady_a");
    wait_strobe_f("steady_b");
    chk("steady_r", f_last_r, 255);
    chk("steady_g", f_last_g, 0);
    chk("steady_b", f_last_b, 128);
    wait_strobe_f("refade_a");
    chk("refade_r", f_last_r, 254);
    chk("refade_g", f_last_g, 1);
    chk("refade_b", f_last_b, 127);
    for (int k = 259; k <= 306; k++) wait_strobe_f("refade_run");
    repeat (20) tick();
    chk("pre_reset_lit", f_led_r, 0);
    #2 rst_n_f = 1'b0;
    #1;
    chk("rst_async_leds", {f_led_r, f_led_g, f_led_b}, 7);
    chk("rst_async_ready", if_fast.COLOR_READY, 1);
    chk("rst_async_busy", f_busy, 0);
    repeat (3) tick();
    rst_n_f = 1'b1;
    wait_strobe_f("post_rst_a");
    wait_strobe_f("post_rst_b");
    chk("post_rst_off", f_last_r + f_last_g + f_last_b, 0);
    chk("post_rst_ready", if_fast.COLOR_READY, 1);
  endtask

  task automatic proc_mid();
    repeat (100) tick();
    if_mid.COLOR_VALID = 1'b1;
    if_mid.COLOR_RGB   = 12'h103;
    tick();
    chk("mid_ready_low", if_mid.COLOR_READY, 0);
    if_mid.COLOR_VALID = 1'b0;
    for (int i = 0; i < 30000 && m_win < 8; i++) tick();
    chk("mid_windows", int'(m_win >= 8), 1);
    chk("mid_r_frame0", m_hist_r[0], 0);
    chk("mid_r_frame2", m_hist_r[2], 0);
    chk("mid_r_level1", m_hist_r[3], 188);
    chk("mid_b_frame3", m_hist_b[3], 188);
    chk("mid_b_frame4", m_hist_b[4], 188);
    chk("mid_b_frame5", m_hist_b[5], 376);
    chk("mid_b_frame7", m_hist_b[7], 564);
    chk("mid_ready_done", if_mid.COLOR_READY, 1);
  endtask

  initial begin
    rst_n   = 1'b0;
    rst_n_f = 1'b0;
    if_def.COLOR_VALID  = 1'b0; if_def.COLOR_RGB  = '0;
    if_fast.COLOR_VALID = 1'b0; if_fast.COLOR_RGB = '0;
    if_mid.COLOR_VALID  = 1'b0; if_mid.COLOR_RGB  = '0;
    repeat (3) @(posedge clk);
    tick();
    chk("rst_leds", {d_led_r, d_led_g, d_led_b}, 7);
    chk("rst_ready", if_def.COLOR_READY, 1);
    chk("rst_busy", d_busy, 0);
    chk("rst_strobe", d_strobe, 0);
    chk("rst_fast_ready", if_fast.COLOR_READY, 1);
    rst_n   = 1'b1;
    rst_n_f = 1'b1;
    fork
      proc_def();
      proc_fast();
      proc_mid();
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_fader.md
# rgb_pwm_fader

Drives the board's tri-colour LED (LED_R/LED_G/LED_B, active-low) with per-channel PWM and replaces on/off blinking with smooth colour fades. Upstream logic (the blinky/status generator or a future CPU register bank) submits a 24-bit target colour over a valid/ready handshake. The block ramps each channel one level at a time toward the target, updating only at PWM frame boundaries.

## Interface
- PWM_BITS, 8, resolution of each channel level and of the PWM counter
- PRESCALE, 188, CLK_48 cycles per PWM count (default frame = 188*256 = 48128 cycles ≈ 997 Hz)
- FADE_FRAMES, 4, PWM frames per one-level fade step (≥1)

- CLK_48  in  1  system clock, 48 MHz
- RST_N  in  1  asynchronous, active-low reset
- COLOR_VALID  in  1  target colour offered
- COLOR_RGB  in  3*PWM_BITS  target {R,G,B}, R in MSBs
- COLOR_READY  out  1  block can accept a target
- FADE_BUSY  out  1  fade in progress
- FRAME_STROBE  out  1  one-cycle pulse at each PWM frame start
- LED_R, LED_G, LED_B  out  1 each  active-low PWM outputs (0 = lit)

## Operation
- Prescaler counts 0..PRESCALE-1 and wraps. A tick occurs on the cycle when it equals PRESCALE-1.
- pwm_ctr (PWM_BITS wide) increments on each tick and wraps from 2^PWM_BITS-1 to 0. A frame-start event is a tick while pwm_ctr = 2^PWM_BITS-1.
- Per channel: cur_x (current level), tgt_x (target), shd_x (displayed level). At each frame-start event shd_x <= cur_x. The same edge's fade step changes cur_x, so the new level is displayed from the next frame. No mid-frame duty changes.
- LED_x is registered: LED_x <= ~(pwm_ctr < shd_x). Level 0 is always off. Level L is lit for L*PRESCALE cycles per frame, so max duty is (2^N-1)/2^N.
- State machine IDLE/FADING:
  - IDLE: COLOR_READY=1, FADE_BUSY=0. VALID&&READY latches COLOR_RGB into tgt_x, clears fade_cnt and moves to FADING.
  - FADING: READY=0, BUSY=1. At each frame-start event fade_cnt increments. When it reaches FADE_FRAMES-1 it wraps to 0 and every cur_x with cur_x≠tgt_x moves by ±1 toward tgt_x (saturating at target, never overshooting). Return to IDLE on the first cycle in which cur_x==tgt_x for all channels.
- A target equal to current is still accepted: FADING lasts exactly 1 cycle.
- COLOR_VALID while READY=0 is ignored and tgt_x is unchanged. A held VALID is accepted on the first READY=1 cycle.
- Channels fade independently. Fade time = max|Δ| * FADE_FRAMES frames.

## Timing
- Reset values (immediate on RST_N low): prescaler, pwm_ctr, fade_cnt, cur_x, tgt_x, shd_x = 0. State IDLE. COLOR_READY=1, FADE_BUSY=0, FRAME_STROBE=0, LED_R/G/B=1.
- Reset mid-fade aborts the fade: all of the above apply and the target is lost.
- FRAME_STROBE is registered and is high for the single cycle after a frame-start event, coinciding with pwm_ctr=0, prescaler=0. The first pulse comes PRESCALE*2^PWM_BITS cycles after the first rising edge with RST_N high. Pulses then repeat with that period and are unaffected by handshakes.
- Handshake: READY falls the cycle after acceptance. READY rises the cycle after the last channel reaches target. FADE_BUSY = ~COLOR_READY always.
- LED_x lags pwm_ctr/shd_x by one cycle.
- Coincident acceptance and frame-start event: the frame-start loads shd_x from the old cur_x. fade_cnt is cleared by the acceptance, and that frame-start does not count toward the first step.

## Test plan
- Reset: RST_N low → LEDs=1, READY=1, BUSY=0, STROBE=0. Release → first STROBE at cycle 48128, next at 96256.
- Fade with PRESCALE=1, FADE_FRAMES=1: from reset, submit {255,0,128} → READY low next cycle. B reaches 128 after 128 frames, R reaches 255 after 255 frames. READY returns 1 cycle after R=255. Steady-state LED_R low 255 of 256 cycles, LED_G constant 1, LED_B low 128 of 256.
- Equal target: from reset, submit {0,0,0} → READY low for exactly 1 cycle, LEDs stay 1.
- Busy rejection: during a fade, pulse VALID with {10,10,10} → tgt unchanged, fade completes to original target. Then hold VALID with {10,10,10} → accepted on the first READY=1 cycle.
- Duty boundaries (default params): level 1 → LED low exactly 188 cycles per frame. Level 0 → never low. Mid-frame accepted change → duty changes only at the frame boundary.
- Reset mid-fade: assert RST_N at step 50 → LEDs=1 and READY=1 asynchronously. After release, outputs stay off until a new target is accepted.
